// File: rtl/regfile_scoreboard.sv
// 32-entry register file with a per-register busy scoreboard for RAW hazard stalls.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  ctrl_writeEnable,
  input  logic [31:0]           ctrl_writeSelect,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic                  ctrl_issueValid,
  input  logic [31:0]           ctrl_issueSelect,
  input  logic [4:0]            ctrl_readRegA,
  input  logic [4:0]            ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  output logic                  busy_A,
  output logic                  busy_B,
  output logic [31:0]           busy_vec,
  output logic                  sel_error
);

  if (NUM_REGS != 32) begin : g_num_regs_check
    $error("regfile_scoreboard: NUM_REGS must be 32");
  end

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [31:0]           busy_q, busy_d;
  logic                  sel_error_q, sel_error_d;

  logic wr_zero, wr_onehot, wr_ok, wr_multi;
  logic is_zero, is_onehot, is_ok, is_multi;

  // A select is one-hot when non-zero and clearing its lowest set bit leaves nothing.
  always_comb begin
    wr_zero   = (ctrl_writeSelect == 32'd0);
    wr_onehot = !wr_zero && ((ctrl_writeSelect & (ctrl_writeSelect - 32'd1)) == 32'd0);
    wr_ok     = ctrl_writeEnable && wr_onehot;
    wr_multi  = ctrl_writeEnable && !wr_zero && !wr_onehot;
    is_zero   = (ctrl_issueSelect == 32'd0);
    is_onehot = !is_zero && ((ctrl_issueSelect & (ctrl_issueSelect - 32'd1)) == 32'd0);
    is_ok     = ctrl_issueValid && is_onehot;
    is_multi  = ctrl_issueValid && !is_zero && !is_onehot;
  end

  always_comb begin
    regs_d      = regs_q;
    busy_d      = busy_q;
    sel_error_d = sel_error_q || wr_multi || is_multi;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wr_ok && ctrl_writeSelect[i]) begin
        regs_d[i] = data_writeReg;
        busy_d[i] = 1'b0;
      end
      // A new issue wins over a retiring writeback to the same register.
      if (is_ok && ctrl_issueSelect[i]) begin
        busy_d[i] = 1'b1;
      end
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= 32'd0;
      sel_error_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      sel_error_q <= sel_error_d;
    end
  end

  always_comb begin
    data_readRegA = (ctrl_readRegA == 5'd0) ? '0 : regs_q[ctrl_readRegA];
    data_readRegB = (ctrl_readRegB == 5'd0) ? '0 : regs_q[ctrl_readRegB];
    busy_A        = busy_q[ctrl_readRegA];
    busy_B        = busy_q[ctrl_readRegB];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_ok && ctrl_writeSelect[ctrl_readRegA] && (ctrl_readRegA != 5'd0)) begin
      data_readRegA = data_writeReg;
      busy_A        = is_ok && ctrl_issueSelect[ctrl_readRegA];
    end
    if (wr_ok && ctrl_writeSelect[ctrl_readRegB] && (ctrl_readRegB != 5'd0)) begin
      data_readRegB = data_writeReg;
      busy_B        = is_ok && ctrl_issueSelect[ctrl_readRegB];
    end
`endif
  end

  assign busy_vec  = busy_q;
  assign sel_error = sel_error_q;

endmodule
